// File: rtl/hazard_stall_controller_pkg.sv
// Shared decode constants, MDU state encoding and instruction-class helpers
// used by the hazard controller and the decode-stage controller.
package hazard_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_SPECIAL3 = 6'b011111;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [5:0] F2_MADD  = 6'b000000;
  localparam logic [5:0] F2_MADDU = 6'b000001;
  localparam logic [5:0] F2_MUL   = 6'b000010;
  localparam logic [5:0] F2_MSUB  = 6'b000100;
  localparam logic [5:0] F2_MSUBU = 6'b000101;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [5:0] op, input logic [5:0] funct);
    return ((op == OP_SPECIAL) && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU})) ||
           ((op == OP_SPECIAL2) && (funct inside {F2_MADD, F2_MADDU, F2_MSUB, F2_MSUBU, F2_MUL}));
  endfunction

  function automatic logic is_div_op(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_SPECIAL) && (funct inside {FN_DIV, FN_DIVU});
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_SPECIAL) && (funct inside {FN_MFHI, FN_MFLO});
  endfunction

  function automatic logic uses_rs(input logic [5:0] op, input logic [5:0] funct);
    return !((op inside {OP_J, OP_JAL, OP_LUI}) ||
             ((op == OP_SPECIAL) && (funct inside {FN_SLL, FN_SRL, FN_SRA})));
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_SPECIAL, OP_SPECIAL2, OP_SPECIAL3, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};
  endfunction

  // Instructions whose operands are compared in ID and so need them one stage early.
  function automatic logic is_id_branch(input logic [5:0] op, input logic [5:0] funct);
    return (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM}) ||
           ((op == OP_SPECIAL) && (funct == FN_JR));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Decode-stage view of the pipeline: ID/EX/MEM hazard inputs and the
// stage-enable, flush and MDU sequencing outputs of the hazard controller.
interface hazard_stall_controller_if #(
  parameter int PERF_WIDTH = 32
);
  logic [5:0]            IFID_OpCode;
  logic [5:0]            IFID_Funct;
  logic [4:0]            IFID_Rs;
  logic [4:0]            IFID_Rt;
  logic                  IDEX_MemRead;
  logic                  IDEX_RegWrite;
  logic [4:0]            IDEX_WriteReg;
  logic                  EXMEM_MemRead;
  logic [4:0]            EXMEM_WriteReg;
  logic                  BranchTaken;
  logic                  JumpTaken;
  logic                  PCWrite;
  logic                  IFID_Write;
  logic                  IFID_Flush;
  logic                  IDEX_Bubble;
  logic                  MduStart;
  logic                  MduBusy;
  logic                  MduDone;
  logic [PERF_WIDTH-1:0] StallCycles;

  modport master (
    output IFID_OpCode, IFID_Funct, IFID_Rs, IFID_Rt,
    output IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
    output EXMEM_MemRead, EXMEM_WriteReg, BranchTaken, JumpTaken,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
    input  MduStart, MduBusy, MduDone, StallCycles
  );

  modport slave (
    input  IFID_OpCode, IFID_Funct, IFID_Rs, IFID_Rt,
    input  IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
    input  EXMEM_MemRead, EXMEM_WriteReg, BranchTaken, JumpTaken,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
    output MduStart, MduBusy, MduDone, StallCycles
  );
endinterface

// File: rtl/hazard_stall_controller_mdu_sequencer.sv
// IDLE/BUSY sequencer for the multi-cycle multiply/divide unit: issues the
// start pulse, tracks the latency down-counter and flags the final busy cycle.
module mdu_sequencer
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_WIDTH   = 6
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_mdu_op,
  input  logic i_is_div,
  input  logic i_stall,
  output logic o_start,
  output logic o_busy,
  output logic o_done
);

  mdu_state_e           r_state;
  mdu_state_e           w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_start;
  logic                 w_done;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (i_mdu_op && !i_stall) begin
          w_start      = 1'b1;
          w_state_next = MDU_BUSY;
          w_cnt_next   = i_is_div ? CNT_WIDTH'(DIV_LATENCY - 1) : CNT_WIDTH'(MUL_LATENCY - 1);
        end
      end
      MDU_BUSY: begin
        // Counter reaching zero marks the cycle whose closing edge writes HI/LO.
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_done       = 1'b1;
          w_state_next = MDU_IDLE;
        end
      end
      default: w_state_next = MDU_IDLE;
    endcase
  end

  assign o_start = w_start & ~Reset;
  assign o_done  = w_done & ~Reset;
  assign o_busy  = (r_state == MDU_BUSY) & ~Reset;

endmodule

// File: rtl/hazard_stall_controller.sv
// Decides each cycle whether fetch, IF/ID and ID/EX advance, stall or flush,
// sequences the MDU and counts stalled cycles.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_WIDTH   = 6,
  parameter int PERF_WIDTH  = 32
) (
  input  logic                        Clock,
  input  logic                        Reset,
  hazard_stall_controller_if.slave    bus
);

  logic                  w_use_rs;
  logic                  w_use_rt;
  logic                  w_ex_match;
  logic                  w_mem_match;
  logic                  w_load_use;
  logic                  w_branch_haz;
  logic                  w_mdu_haz;
  logic                  w_stall;
  logic                  w_mdu_op;
  logic                  w_mdu_busy;
  logic [PERF_WIDTH-1:0] r_stall_cycles;

  assign w_use_rs = uses_rs(bus.IFID_OpCode, bus.IFID_Funct);
  assign w_use_rt = uses_rt(bus.IFID_OpCode);
  assign w_mdu_op = is_mdu_op(bus.IFID_OpCode, bus.IFID_Funct);

  // $0 is never a real producer, so it can never create a dependency.
  assign w_ex_match  = (bus.IDEX_WriteReg != 5'd0) &&
                       ((w_use_rs && (bus.IDEX_WriteReg == bus.IFID_Rs)) ||
                        (w_use_rt && (bus.IDEX_WriteReg == bus.IFID_Rt)));
  assign w_mem_match = (bus.EXMEM_WriteReg != 5'd0) &&
                       ((w_use_rs && (bus.EXMEM_WriteReg == bus.IFID_Rs)) ||
                        (w_use_rt && (bus.EXMEM_WriteReg == bus.IFID_Rt)));

  assign w_load_use   = bus.IDEX_MemRead & w_ex_match;
  assign w_branch_haz = is_id_branch(bus.IFID_OpCode, bus.IFID_Funct) &
                        ((bus.IDEX_RegWrite & w_ex_match) | (bus.EXMEM_MemRead & w_mem_match));
  assign w_mdu_haz    = w_mdu_busy & (w_mdu_op | is_hilo_read(bus.IFID_OpCode, bus.IFID_Funct));
  assign w_stall      = w_load_use | w_branch_haz | w_mdu_haz;

  mdu_sequencer #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_mdu_seq (
    .Clock    (Clock),
    .Reset    (Reset),
    .i_mdu_op (w_mdu_op),
    .i_is_div (is_div_op(bus.IFID_OpCode, bus.IFID_Funct)),
    .i_stall  (w_stall),
    .o_start  (bus.MduStart),
    .o_busy   (w_mdu_busy),
    .o_done   (bus.MduDone)
  );

  assign bus.MduBusy = w_mdu_busy;

  // Branch/jump resolution is ignored while stalled: its operands are stale.
  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IFID_Write  = 1'b1;
    bus.IFID_Flush  = bus.BranchTaken | bus.JumpTaken;
    bus.IDEX_Bubble = 1'b0;
    if (Reset) begin
      bus.PCWrite     = 1'b0;
      bus.IFID_Write  = 1'b0;
      bus.IFID_Flush  = 1'b1;
      bus.IDEX_Bubble = 1'b1;
    end else if (w_stall) begin
      bus.PCWrite     = 1'b0;
      bus.IFID_Write  = 1'b0;
      bus.IFID_Flush  = 1'b0;
      bus.IDEX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.StallCycles = Reset ? '0 : r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed scoreboard bench for hazard_stall_controller: each step drives one
// cycle of pipeline state, queues the expected controls and checks them mid-cycle.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  typedef struct {
    string       tag;
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        bubble;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  hazard_stall_controller_if #(.PERF_WIDTH(32)) bus ();

  hazard_stall_controller #(
    .MUL_LATENCY (4),
    .DIV_LATENCY (32),
    .CNT_WIDTH   (6),
    .PERF_WIDTH  (32)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_all();
    bus.IFID_OpCode    = 6'd0;
    bus.IFID_Funct     = 6'd0;
    bus.IFID_Rs        = 5'd0;
    bus.IFID_Rt        = 5'd0;
    bus.IDEX_MemRead   = 1'b0;
    bus.IDEX_RegWrite  = 1'b0;
    bus.IDEX_WriteReg  = 5'd0;
    bus.EXMEM_MemRead  = 1'b0;
    bus.EXMEM_WriteReg = 5'd0;
    bus.BranchTaken    = 1'b0;
    bus.JumpTaken      = 1'b0;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt);
    bus.IFID_OpCode = op;
    bus.IFID_Funct  = fn;
    bus.IFID_Rs     = rs;
    bus.IFID_Rt     = rt;
  endtask

  task automatic set_ex(input logic mr, input logic rw, input logic [4:0] wr);
    bus.IDEX_MemRead  = mr;
    bus.IDEX_RegWrite = rw;
    bus.IDEX_WriteReg = wr;
  endtask

  task automatic set_mem(input logic mr, input logic [4:0] wr);
    bus.EXMEM_MemRead  = mr;
    bus.EXMEM_WriteReg = wr;
  endtask

  // One clock: queue expectation, compare at the falling edge, advance model.
  task automatic step(input string tag, input bit st, input bit fl, input bit sta, input bit bu, input bit dn);
    exp_t e;
    exp_t g;
    e.tag = tag;
    if (rst) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b1; e.bubble = 1'b1;
      e.start = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.cnt = 32'd0;
    end else begin
      e.pcw = !st; e.ifw = !st; e.flush = fl; e.bubble = st;
      e.start = sta; e.busy = bu; e.done = dn; e.cnt = model_cnt;
    end
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check({g.tag, ".PCWrite"},     {31'd0, bus.PCWrite},     {31'd0, g.pcw});
    check({g.tag, ".IFID_Write"},  {31'd0, bus.IFID_Write},  {31'd0, g.ifw});
    check({g.tag, ".IFID_Flush"},  {31'd0, bus.IFID_Flush},  {31'd0, g.flush});
    check({g.tag, ".IDEX_Bubble"}, {31'd0, bus.IDEX_Bubble}, {31'd0, g.bubble});
    check({g.tag, ".MduStart"},    {31'd0, bus.MduStart},    {31'd0, g.start});
    check({g.tag, ".MduBusy"},     {31'd0, bus.MduBusy},     {31'd0, g.busy});
    check({g.tag, ".MduDone"},     {31'd0, bus.MduDone},     {31'd0, g.done});
    check({g.tag, ".StallCycles"}, bus.StallCycles,          g.cnt);
    $display("step %-14s pcw=%0b ifw=%0b flush=%0b bubble=%0b start=%0b busy=%0b done=%0b stalls=%0d",
             g.tag, bus.PCWrite, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Bubble,
             bus.MduStart, bus.MduBusy, bus.MduDone, bus.StallCycles);
    if (rst) model_cnt = 0;
    else if (st) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    @(posedge clk);
    #1;
    step("reset0", 0, 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("idle", 0, 0, 0, 0, 0);

    // LW $2 in EX, ADD $3,$2,$4 in ID
    set_ex(1, 1, 5'd2); set_id(6'b000000, 6'b100000, 5'd2, 5'd4);
    step("lu_stall", 1, 0, 0, 0, 0);
    set_ex(0, 0, 5'd0); set_mem(1, 5'd2);
    step("lu_go", 0, 0, 0, 0, 0);
    clear_all();

    // LW $5 then BEQ $5,$0 taken: two stalls, then flush
    set_ex(1, 1, 5'd5); set_id(6'b000100, 6'd0, 5'd5, 5'd0); bus.BranchTaken = 1'b1;
    step("beq_ld_s1", 1, 0, 0, 0, 0);
    set_ex(0, 0, 5'd0); set_mem(1, 5'd5);
    step("beq_ld_s2", 1, 0, 0, 0, 0);
    set_mem(0, 5'd0);
    step("beq_flush", 0, 1, 0, 0, 0);
    clear_all();

    // ALU result feeding BNE / JR: one stall each
    set_ex(0, 1, 5'd6); set_id(6'b000101, 6'd0, 5'd1, 5'd6); bus.BranchTaken = 1'b1;
    step("bne_alu_s", 1, 0, 0, 0, 0);
    set_ex(0, 0, 5'd0);
    step("bne_flush", 0, 1, 0, 0, 0);
    clear_all();
    set_ex(0, 1, 5'd7); set_id(6'b000000, 6'b001000, 5'd7, 5'd0); bus.JumpTaken = 1'b1;
    step("jr_alu_s", 1, 0, 0, 0, 0);
    set_ex(0, 0, 5'd0);
    step("jr_flush", 0, 1, 0, 0, 0);
    clear_all();

    // SW uses rt; SLL does not use rs
    set_ex(1, 1, 5'd9); set_id(6'b101011, 6'd0, 5'd1, 5'd9);
    step("sw_rt_stall", 1, 0, 0, 0, 0);
    set_ex(1, 1, 5'd2); set_id(6'b000000, 6'b000000, 5'd2, 5'd0);
    step("sll_no_rs", 0, 0, 0, 0, 0);
    clear_all();

    // Register 0 never matches
    set_ex(1, 1, 5'd0); set_id(6'b000000, 6'b100000, 5'd0, 5'd0);
    step("r0_load", 0, 0, 0, 0, 0);
    set_mem(1, 5'd0); set_id(6'b000100, 6'd0, 5'd0, 5'd0); bus.BranchTaken = 1'b1;
    step("r0_beq", 0, 1, 0, 0, 0);
    clear_all();

    // MULT then dependent MFLO
    set_id(6'b000000, 6'b011000, 5'd1, 5'd2);
    step("mult_issue", 0, 0, 1, 0, 0);
    set_id(6'b000000, 6'b010010, 5'd0, 5'd3);
    for (int i = 1; i <= 4; i++) step("mflo_wait", 1, 0, 0, 1, (i == 4));
    step("mflo_go", 0, 0, 0, 0, 0);
    clear_all();

    // DIV then independent ADDIs; a jump mid-busy flushes without disturbing the MDU
    set_id(6'b000000, 6'b011010, 5'd3, 5'd4);
    step("div_issue", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      set_id((i == 10) ? 6'b000010 : 6'b001000, 6'd0, 5'd5, 5'd6);
      bus.JumpTaken = (i == 10);
      step("div_addi", 0, (i == 10), 0, 1, (i == 32));
    end
    clear_all();
    step("div_after", 0, 0, 0, 0, 0);

    // Load-use stall coinciding with MULT in ID delays the issue
    set_ex(1, 1, 5'd1); set_id(6'b000000, 6'b011000, 5'd1, 5'd2);
    step("mult_lu_hold", 1, 0, 0, 0, 0);
    set_ex(0, 0, 5'd0); set_mem(1, 5'd1);
    step("mult_lu_go", 0, 0, 1, 0, 0);
    clear_all();
    for (int i = 1; i <= 4; i++) step("mult_busy", 0, 0, 0, 1, (i == 4));
    step("mult_after", 0, 0, 0, 0, 0);

    // SPECIAL2 MUL in ID during busy stalls as a back-to-back MDU op
    set_id(6'b011100, 6'b000010, 5'd1, 5'd2);
    step("mul_issue", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step("mul_b2b", 1, 0, 0, 1, (i == 4));
    step("mul_b2b_go", 0, 0, 1, 0, 0);
    clear_all();
    for (int i = 1; i <= 4; i++) step("mul2_busy", 0, 0, 0, 1, (i == 4));

    // Reset at the 10th busy cycle of DIV
    set_id(6'b000000, 6'b011011, 5'd3, 5'd4);
    step("divu_issue", 0, 0, 1, 0, 0);
    clear_all();
    for (int i = 1; i <= 9; i++) step("divu_busy", 0, 0, 0, 1, 0);
    rst = 1'b1;
    step("mid_reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 1; i <= 25; i++) step("post_reset", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencer that sits beside the decode-stage controller and decides each cycle whether the fetch, IF/ID and ID/EX stages advance, stall or flush. It covers three cases:
- load-use hazards;
- branch/JR operand hazards, since branches resolve in ID;
- busy/issue sequencing of the multi-cycle multiply/divide unit (MDU) that owns HI/LO.

It also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LATENCY, 4, cycles MDU stays busy for MULT/MULTU/MADD/MSUB/MUL (min 1)
DIV_LATENCY, 32, cycles MDU stays busy for DIV/DIVU (min 1)
CNT_WIDTH, 6, width of MDU down-counter; must hold max latency-1
PERF_WIDTH, 32, width of StallCycles counter

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
IFID_OpCode  in  6  opcode of instruction in ID
IFID_Funct  in  6  funct field of instruction in ID
IFID_Rs  in  5  rs of instruction in ID
IFID_Rt  in  5  rt of instruction in ID
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_RegWrite  in  1  instruction in EX writes a GPR
IDEX_WriteReg  in  5  destination register of instruction in EX
EXMEM_MemRead  in  1  instruction in MEM is a load
EXMEM_WriteReg  in  5  destination register of instruction in MEM
BranchTaken  in  1  ID-stage branch comparator result (conditional branch taken)
JumpTaken  in  1  J/JAL/JR decoded in ID
PCWrite  out  1  PC register enable
IFID_Write  out  1  IF/ID register enable
IFID_Flush  out  1  clear IF/ID to NOP
IDEX_Bubble  out  1  zero control fields entering ID/EX
MduStart  out  1  one-cycle issue pulse to the MDU
MduBusy  out  1  MDU state is BUSY
MduDone  out  1  one-cycle pulse in the final busy cycle; HI/LO written at that edge
StallCycles  out  PERF_WIDTH  count of stalled cycles, saturating

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high, sampled on the rising edge of Clock.
- While Reset is high (combinational override), and after the reset edge:
  - PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1;
  - MduStart=0, MduDone=0, MduBusy=0;
  - state=IDLE, counter=0, StallCycles=0.
- Source-use decode, for the instruction in ID:
  - Rs is used by all opcodes except J, JAL, LUI and the shifts SLL/SRL/SRA (000000 with funct 000000/000010/000011).
  - Rt is used by R-type (000000), SPECIAL2 (011100), SEB/SEH (011111), BEQ, BNE, SB, SH, SW.
  - Register 0 never matches.
- LoadUse: IDEX_MemRead and IDEX_WriteReg equals a used source.
- BranchHaz: applies when ID holds BEQ/BNE/BLEZ/BGTZ/REGIMM (000001) or JR. The hazard is either of:
  - IDEX_RegWrite and IDEX_WriteReg equals a used source;
  - EXMEM_MemRead and EXMEM_WriteReg equals a used source.
  - A load in EX therefore stalls 2 cycles; an ALU op in EX stalls 1 cycle.
- MDU ops:
  - 000000 with funct 011000–011011 (MULT/MULTU/DIV/DIVU).
  - 011100 with funct 000000/000001/000100/000101/000010 (MADD/MADDU/MSUB/MSUBU/MUL).
- HI/LO readers: 000000 with funct 010000/010010 (MFHI/MFLO).
- MduHaz: state==BUSY and ID holds an MDU op or a HI/LO reader.
- Stall = LoadUse | BranchHaz | MduHaz. On Stall:
  - PCWrite=0, IFID_Write=0, IDEX_Bubble=1;
  - IFID_Flush=0, MduStart=0;
  - BranchTaken/JumpTaken are ignored, because their operands are invalid.
- No stall:
  - PCWrite=1, IFID_Write=1, IDEX_Bubble=0.
  - IFID_Flush = BranchTaken | JumpTaken. There is no delay slot: the wrongly-fetched instruction is squashed.
- MDU FSM, states IDLE and BUSY:
  - IDLE: if ID holds an MDU op and Stall=0, then MduStart=1. On the next edge, load counter with latency-1 (DIV_LATENCY for DIV/DIVU, else MUL_LATENCY) and go to BUSY.
  - BUSY: MduBusy=1. If counter≠0, decrement. If counter==0, MduDone=1 and go to IDLE on the next edge.
  - An op issued at cycle t keeps BUSY for cycles t+1..t+L.
  - A dependent MFHI/MFLO or back-to-back MDU op stalls through t+L and issues at t+L+1. Independent instructions flow freely during BUSY.
- Simultaneous events:
  - A load-use stall coinciding with an MDU op in ID suppresses MduStart; the op issues once the stall clears.
  - BranchTaken during BUSY with no hazard flushes normally; the MDU keeps running.
- Reset mid-BUSY: return to IDLE immediately with no MduDone pulse. The MDU itself is reset by the same Reset.
- StallCycles increments on every cycle with Stall=1 and Reset=0, and saturates at all-ones.

Decomposition:
- Shared package (hazard_pkg):
  - opcode and funct localparams (shared with the decode controller);
  - IDLE/BUSY state encoding;
  - MDU-op and HI/LO-reader decode functions.
- Sub-module mdu_sequencer: IDLE/BUSY FSM, latency down-counter, MduStart/MduBusy/MduDone.
- Hazard detection and the perf counter stay in the top module.

Test Plan:
- LW $2 in EX (IDEX_MemRead=1, IDEX_WriteReg=2); ADD $3,$2,$4 in ID -> one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle all advance; StallCycles=1.
- LW $5 in EX; BEQ $5,$0 in ID -> 2 stall cycles, the second from EXMEM_MemRead match. BranchTaken=1 is ignored during the stall; on the third cycle IFID_Flush=1.
- MULT $1,$2 issued at t (MduStart=1), MFLO at t+1 -> MduBusy t+1..t+4, MduDone at t+4, MFLO stalls 4 cycles, issues t+5.
- DIV then independent ADDI -> ADDI advances with no stall; MduBusy stays high for 32 cycles.
- Reset asserted at 10th busy cycle of DIV -> next cycle MduBusy=0, MduDone never pulses, StallCycles=0.
- Any hazard with source register 0 (e.g. LW $0 in EX, ADD using $0) -> no stall.
